// File: rtl/gf233_sqr_chain.sv
// Repeated-squaring engine over GF(2^233), f(x) = x^233 + x^74 + 1: d_out = a_in^(2^n).
// Two squarings per cycle through gf233_pow4, plus one pow2 step when the count is odd.

module gf233_pow4 (
    input  logic [232:0] x,
    output logic [232:0] y
);
    logic [2:0][232:0] stg;

    assign stg[0] = x;

    for (genvar s = 0; s < 2; s++) begin : g_stage
        logic [465:0] w;
        logic [232:0] hi;
        logic [306:0] f1;
        logic [73:0]  f2;

        for (genvar gi = 0; gi < 233; gi++) begin : g_spread
            assign w[2*gi]   = stg[s][gi];
            assign w[2*gi+1] = 1'b0;
        end

        // x^233 = x^74 + 1; the folded upper part reaches x^305 and needs one more fold.
        assign hi = w[465:233];
        assign f1 = {74'b0, hi} ^ {hi, 74'b0};
        assign f2 = f1[306:233];
        assign stg[s+1] = w[232:0] ^ f1[232:0] ^ {159'b0, f2} ^ {85'b0, f2, 74'b0};
    end

    assign y = stg[2];
endmodule

module gf233_sqr_chain #(
    parameter int M  = 233,
    parameter int NW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NW-1:0] n,
    input  logic [M-1:0]  a_in,
    output logic          busy,
    output logic          done,
    output logic [M-1:0]  d_out
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [M-1:0]  acc_q, acc_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [M-1:0]  d_out_q, d_out_d;
    logic [NW-1:0] n_eff;
    logic [M-1:0]  acc_pow4;
    logic [M-1:0]  acc_pow2;

    gf233_pow4 u_pow4 (
        .x (acc_q),
        .y (acc_pow4)
    );

    // Single squaring network for the odd leftover step.
    logic [2*M-1:0] sq_w;
    logic [M-1:0]   sq_hi;
    logic [M+73:0]  sq_f1;
    logic [73:0]    sq_f2;

    for (genvar gi = 0; gi < M; gi++) begin : g_sq_spread
        assign sq_w[2*gi]   = acc_q[gi];
        assign sq_w[2*gi+1] = 1'b0;
    end

    assign sq_hi    = sq_w[2*M-1:M];
    assign sq_f1    = {74'b0, sq_hi} ^ {sq_hi, 74'b0};
    assign sq_f2    = sq_f1[M+73:M];
    assign acc_pow2 = sq_w[M-1:0] ^ sq_f1[M-1:0] ^ {159'b0, sq_f2} ^ {85'b0, sq_f2, 74'b0};

    // a^(2^233) = a, so counts of 233 and above wrap down by one full period.
    always_comb begin
        n_eff = (n < NW'(M)) ? n : n - NW'(M);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        d_out_d = d_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = a_in;
                    cnt_d   = n_eff;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q >= NW'(2)) begin
                    acc_d = acc_pow4;
                    cnt_d = cnt_q - NW'(2);
                end else if (cnt_q == NW'(1)) begin
                    acc_d = acc_pow2;
                    cnt_d = '0;
                end else begin
                    d_out_d = acc_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_out_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            d_out_q <= d_out_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign d_out = d_out_q;
endmodule

// File: tb/tb_gf233_sqr_chain.sv
// Bench for gf233_sqr_chain: schoolbook GF(2^233) model, per-cycle output compare, directed and random ops.

module tb_gf233_sqr_chain;
    localparam int M  = 233;
    localparam int NW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NW-1:0] n;
    logic [M-1:0]  a_in;
    logic          busy;
    logic          done;
    logic [M-1:0]  d_out;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    gf233_sqr_chain #(.M(M), .NW(NW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .n     (n),
        .a_in  (a_in),
        .busy  (busy),
        .done  (done),
        .d_out (d_out)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
        logic [2*M-1:0] p;
        p = '0;
        for (int i = 0; i < M; i++)
            if (y[i]) p = p ^ ({{M{1'b0}}, x} << i);
        for (int k = 2*M-2; k >= M; k--)
            if (p[k]) begin
                p[k]       = 1'b0;
                p[k-M]     = ~p[k-M];
                p[k-M+74]  = ~p[k-M+74];
            end
        return p[M-1:0];
    endfunction

    function automatic logic [M-1:0] model_pow(input logic [M-1:0] a, input int nn);
        logic [M-1:0] r;
        r = a;
        for (int i = 0; i < nn; i++) r = gf_mul(r, r);
        return r;
    endfunction

    function automatic int exp_latency(input int nn);
        int ne;
        ne = (nn < M) ? nn : nn - M;
        return (ne + 1) / 2 + 1;
    endfunction

    function automatic logic [M-1:0] rand233();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
        return t[M-1:0];
    endfunction

    function automatic logic [M-1:0] onehot(input int b);
        logic [M-1:0] t;
        t = '0;
        t[b] = 1'b1;
        return t;
    endfunction

    // ---------------- checkers ----------------
    task automatic chkw(input string nm, input logic [M-1:0] act, input logic [M-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // ---------------- scoreboard / cycle model ----------------
    logic [M-1:0] exp_q[$];
    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;
    logic [M-1:0] m_dout = '0;
    int           m_left = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_dout = '0;
            m_left = 0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_dout = exp_q.pop_front();
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_left = exp_latency(int'(n));
                exp_q.push_back(model_pow(a_in, int'(n)));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chki("cyc_busy", int'(busy), int'(m_busy));
            chki("cyc_done", int'(done), int'(m_done));
            chkw("cyc_d_out", d_out, m_dout);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic [M-1:0] a, input int nn);
        start = 1'b1;
        a_in  = a;
        n     = NW'(nn);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output logic [M-1:0] res, output int lat);
        lat = 0;
        res = '0;
        forever begin
            @(posedge clk);
            #1 lat++;
            if (done) begin
                res = d_out;
                break;
            end
            if (lat > 300) begin
                total_cnt++;
                $display("FAIL done_timeout: no done within %0d edges", lat);
                break;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [M-1:0] a, b, res, lit;
        int lat, nn, seen;

        rst = 1'b1; start = 1'b0; n = '0; a_in = '0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chki("idle_busy", int'(busy), 0);
        chki("idle_done", int'(done), 0);
        chkw("idle_d_out", d_out, '0);

        // Model pinned to hand-reduced values.
        lit = onehot(8) | onehot(82) | onehot(167);
        chkw("model_pin_x200_sq", model_pow(onehot(200), 1), lit);
        lit = onehot(72) | onehot(146) | onehot(231);
        chkw("model_pin_x116_pow4", model_pow(onehot(116), 2), lit);

        // n=0 identity
        start_op(onehot(5), 0);
        wait_done(res, lat);
        chki("n0_latency", lat, 1);
        chkw("n0_result", res, onehot(5));
        chki("n0_busy_at_done", int'(busy), 0);

        // n=1 odd path
        start_op(onehot(200), 1);
        wait_done(res, lat);
        chki("n1_latency", lat, 2);
        chkw("n1_result", res, onehot(8) | onehot(82) | onehot(167));

        // n=2 pow4 path
        start_op(onehot(116), 2);
        wait_done(res, lat);
        chki("n2_latency", lat, 2);
        chkw("n2_result", res, onehot(72) | onehot(146) | onehot(231));

        // n=233 wraps to identity
        a = rand233();
        start_op(a, 233);
        wait_done(res, lat);
        chki("n233_latency", lat, 1);
        chkw("n233_result", res, a);

        // n=232 then n=1 from the done cycle closes the full period
        a = rand233();
        start_op(a, 232);
        wait_done(res, lat);
        chki("n232_latency", lat, 117);
        start_op(res, 1);
        wait_done(res, lat);
        chki("n232_then_n1_latency", lat, 2);
        chkw("full_period_result", res, a);

        // start during RUN is ignored
        a = rand233();
        b = rand233();
        start_op(a, 100);
        repeat (10) @(posedge clk);
        #1 start = 1'b1; a_in = b; n = NW'(3);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(res, lat);
        chki("midrun_start_latency", 11 + lat, 51);
        chkw("midrun_start_result", res, model_pow(a, 100));

        // reset during RUN aborts without a done pulse
        start_op(rand233(), 100);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chki("abort_busy", int'(busy), 0);
        chki("abort_done", int'(done), 0);
        chkw("abort_d_out", d_out, '0);
        seen = 0;
        repeat (120) begin
            @(posedge clk);
            #1 if (done) seen = 1;
        end
        chki("abort_no_done", seen, 0);

        // random back-to-back operations
        for (int t = 0; t < 16; t++) begin
            a  = rand233();
            nn = (t < 2) ? 255 - t : int'($urandom_range(0, 255));
            start_op(a, nn);
            wait_done(res, lat);
            chki("rand_latency", lat, exp_latency(nn));
            chkw("rand_result", res, model_pow(a, nn));
        end

        repeat (4) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
